// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the true dual-port RAM: read-during-write policy
// encodings and the clear sequencer state type.
package tdp_ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

endpackage

// File: rtl/true_dual_port_ram_if.sv
// Port bundle for the true dual-port RAM: two request/response ports plus
// the shared busy and collision status.
interface tdp_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              en_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] dout_a;
  logic              vld_a;

  logic              en_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] din_b;
  logic [DATA_W-1:0] dout_b;
  logic              vld_b;

  logic              busy;
  logic              collision;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    input  dout_a, vld_a, dout_b, vld_b, busy, collision
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    output dout_a, vld_a, dout_b, vld_b, busy, collision
  );

endinterface

// File: rtl/tdp_ram_clear_ctrl.sv
// Clear sequencer: walks every address once after reset, writing zero, and
// holds busy until the last word has been written.
//   state | meaning
//   CLEAR | zeroing address r_cnt this cycle, busy=1
//   READY | array initialised, ports may access it
module tdp_ram_clear_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // The reset cycle itself must not write: rst does not zero the array.
  assign o_clr_we   = r_busy & ~rst;
  assign o_clr_addr = r_cnt;
  assign o_busy     = r_busy;

endmodule

// File: rtl/true_dual_port_ram.sv
// True dual-port RAM with a zeroing clear sequence after reset, selectable
// read-during-write policy, port A write priority and collision flagging.
module true_dual_port_ram
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic   clk,
  input  logic   rst,
  tdp_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout_a;
  logic [DATA_W-1:0] r_dout_b;
  logic              r_vld_a;
  logic              r_vld_b;
  logic              r_coll;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_same;
  logic [DATA_W-1:0] w_old_a;
  logic [DATA_W-1:0] w_old_b;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  tdp_ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_acc_a = bus.en_a & ~w_busy & ~rst;
  assign w_acc_b = bus.en_b & ~w_busy & ~rst;
  assign w_wr_a  = w_acc_a & bus.we_a;
  assign w_wr_b  = w_acc_b & bus.we_b;
  assign w_same  = (bus.addr_a == bus.addr_b);
  assign w_old_a = r_mem[bus.addr_a];
  assign w_old_b = r_mem[bus.addr_b];

  // Write-first forwards the word being written this cycle, from either port.
  always_comb begin
    w_rd_a = w_old_a;
    w_rd_b = w_old_b;
    if (RD_MODE == WR_FIRST) begin
      if (w_wr_a) begin
        w_rd_a = bus.din_a;
      end else if (w_wr_b && w_same) begin
        w_rd_a = bus.din_b;
      end
      if (w_wr_b) begin
        w_rd_b = bus.din_b;
      end else if (w_wr_a && w_same) begin
        w_rd_b = bus.din_a;
      end
    end
  end

  // Port A is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_wr_b) begin
        r_mem[bus.addr_b] <= bus.din_b;
      end
      if (w_wr_a) begin
        r_mem[bus.addr_a] <= bus.din_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_vld_a  <= 1'b0;
      r_vld_b  <= 1'b0;
      r_coll   <= 1'b0;
    end else begin
      r_vld_a <= w_acc_a;
      r_vld_b <= w_acc_b;
      r_coll  <= w_acc_a & w_acc_b & w_same & (bus.we_a | bus.we_b);
      if (w_acc_a) begin
        r_dout_a <= w_rd_a;
      end
      if (w_acc_b) begin
        r_dout_b <= w_rd_b;
      end
    end
  end

  assign bus.dout_a    = r_dout_a;
  assign bus.dout_b    = r_dout_b;
  assign bus.vld_a     = r_vld_a;
  assign bus.vld_b     = r_vld_b;
  assign bus.collision = r_coll;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Bench for true_dual_port_ram: one read-first and one write-first instance
// driven identically and checked against a behavioural memory model.
module tb_true_dual_port_ram;
  import tdp_ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          s_en_a, s_we_a, s_en_b, s_we_b;
  logic [AW-1:0] s_addr_a, s_addr_b;
  logic [DW-1:0] s_din_a, s_din_b;

  tdp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  tdp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.en_a = s_en_a;  assign bus1.en_a = s_en_a;
  assign bus0.we_a = s_we_a;  assign bus1.we_a = s_we_a;
  assign bus0.addr_a = s_addr_a;  assign bus1.addr_a = s_addr_a;
  assign bus0.din_a = s_din_a;  assign bus1.din_a = s_din_a;
  assign bus0.en_b = s_en_b;  assign bus1.en_b = s_en_b;
  assign bus0.we_b = s_we_b;  assign bus1.we_b = s_we_b;
  assign bus0.addr_b = s_addr_b;  assign bus1.addr_b = s_addr_b;
  assign bus0.din_b = s_din_b;  assign bus1.din_b = s_din_b;

  true_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(RD_FIRST)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  true_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(WR_FIRST)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // {dout_a, dout_b, vld_a, vld_b, collision, busy}
  logic [19:0] obs_vec [2];
  assign obs_vec[0] = {bus0.dout_a, bus0.dout_b, bus0.vld_a, bus0.vld_b, bus0.collision, bus0.busy};
  assign obs_vec[1] = {bus1.dout_a, bus1.dout_b, bus1.vld_a, bus1.vld_b, bus1.collision, bus1.busy};

  // Reference model: memory array, remaining clear cycles, expected outputs.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr = DEPTH;
  logic [DW-1:0] e_dout_a [2];
  logic [DW-1:0] e_dout_b [2];
  logic          e_vld_a, e_vld_b, e_coll, e_busy;

  function automatic logic [19:0] exp_vec(int m);
    return {e_dout_a[m], e_dout_b[m], e_vld_a, e_vld_b, e_coll, e_busy};
  endfunction

  task automatic set_io(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    s_en_a = ea; s_we_a = wa; s_addr_a = aa; s_din_a = da;
    s_en_b = eb; s_we_b = wb; s_addr_b = ab; s_din_b = db;
  endtask

  task automatic idle();
    set_io(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Advance the model by one clock using the spec rules, then clock the DUTs.
  task automatic tick();
    logic [DW-1:0] oa, ob;
    logic wa, wb, same;
    if (rst) begin
      m_clr = DEPTH;
      for (int m = 0; m < 2; m++) begin
        e_dout_a[m] = '0;
        e_dout_b[m] = '0;
      end
      e_vld_a = 1'b0; e_vld_b = 1'b0; e_coll = 1'b0;
    end else if (m_clr > 0) begin
      m_mem[DEPTH - m_clr] = '0;
      m_clr = m_clr - 1;
      e_vld_a = 1'b0; e_vld_b = 1'b0; e_coll = 1'b0;
    end else begin
      wa   = s_en_a & s_we_a;
      wb   = s_en_b & s_we_b;
      same = (s_addr_a == s_addr_b);
      oa   = m_mem[s_addr_a];
      ob   = m_mem[s_addr_b];
      e_vld_a = s_en_a;
      e_vld_b = s_en_b;
      e_coll  = s_en_a & s_en_b & same & (s_we_a | s_we_b);
      if (s_en_a) begin
        e_dout_a[0] = oa;
        e_dout_a[1] = wa ? s_din_a : ((wb && same) ? s_din_b : oa);
      end
      if (s_en_b) begin
        e_dout_b[0] = ob;
        e_dout_b[1] = wb ? s_din_b : ((wa && same) ? s_din_a : ob);
      end
      if (wb) m_mem[s_addr_b] = s_din_b;
      if (wa) m_mem[s_addr_a] = s_din_a;
    end
    e_busy = (m_clr > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    rst = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec[m] !== 20'h00001) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", m, obs_vec[m], 20'h00001);
      end
    end
    rst = 1'b0;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus0.busy === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL busy_len got=%0d exp=16", cnt);
    end
    checks++;
    if (bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_done_dut1 got=%b exp=0", bus1.busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(DEPTH - 1 - i), '0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_vec[m] !== {8'h00, 8'h00, 4'b1100}) begin
          failures++;
          $display("FAIL cleared_read dut%0d addr=%0d got=%h exp=%h", m, i, obs_vec[m], {8'h00, 8'h00, 4'b1100});
        end
      end
    end
    idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b1, 1'b1, AW'(i), DW'(i + 1), 1'b0, 1'b0, '0, '0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      tick();
      checks++;
      if (bus0.dout_b !== DW'(i + 1) || bus0.vld_b !== 1'b1 ||
          bus1.dout_b !== DW'(i + 1) || bus1.vld_b !== 1'b1) begin
        failures++;
        $display("FAIL fill_read addr=%0d got=%h/%b,%h/%b exp=%h/1", i,
                 bus0.dout_b, bus0.vld_b, bus1.dout_b, bus1.vld_b, DW'(i + 1));
      end
    end
    idle();
    tick();
    checks++;
    if (bus0.vld_b !== 1'b0 || bus1.vld_b !== 1'b0 || bus0.dout_b !== 8'h10) begin
      failures++;
      $display("FAIL vld_pulse got=%b,%b dout=%h exp=0,0 dout=10", bus0.vld_b, bus1.vld_b, bus0.dout_b);
    end
  endtask

  task automatic test_read_during_write();
    set_io(1'b1, 1'b1, 4'd3, 8'h55, 1'b0, 1'b0, '0, '0);
    tick();
    set_io(1'b1, 1'b1, 4'd3, 8'hAA, 1'b1, 1'b0, 4'd3, '0);
    tick();
    checks++;
    if (bus0.dout_b !== 8'h55 || bus0.collision !== 1'b1) begin
      failures++;
      $display("FAIL rdw_read_first got=%h coll=%b exp=55 coll=1", bus0.dout_b, bus0.collision);
    end
    checks++;
    if (bus1.dout_b !== 8'hAA || bus1.collision !== 1'b1) begin
      failures++;
      $display("FAIL rdw_write_first got=%h coll=%b exp=aa coll=1", bus1.dout_b, bus1.collision);
    end
    set_io(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd3, '0);
    tick();
    checks++;
    if (bus0.dout_b !== 8'hAA || bus1.dout_b !== 8'hAA || bus0.collision !== 1'b0) begin
      failures++;
      $display("FAIL rdw_after got=%h,%h coll=%b exp=aa,aa coll=0", bus0.dout_b, bus1.dout_b, bus0.collision);
    end
    set_io(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd3, '0);
    tick();
    checks++;
    if (bus0.collision !== 1'b0 || bus1.collision !== 1'b0) begin
      failures++;
      $display("FAIL rr_no_collision got=%b,%b exp=0,0", bus0.collision, bus1.collision);
    end
    idle();
  endtask

  task automatic test_write_write();
    set_io(1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 1'b1, 4'd7, 8'h22);
    tick();
    checks++;
    if (bus0.collision !== 1'b1 || bus1.collision !== 1'b1) begin
      failures++;
      $display("FAIL ww_collision got=%b,%b exp=1,1", bus0.collision, bus1.collision);
    end
    set_io(1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (bus0.dout_a !== 8'h11 || bus1.dout_a !== 8'h11) begin
      failures++;
      $display("FAIL ww_a_wins got=%h,%h exp=11", bus0.dout_a, bus1.dout_a);
    end
    idle();
  endtask

  task automatic test_busy_ignore();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_io(1'b1, 1'b1, 4'd2, 8'h77, 1'b1, 1'b1, 4'd2, 8'h77);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (bus0.vld_a !== 1'b0 || bus0.vld_b !== 1'b0 || bus1.vld_a !== 1'b0 ||
          bus0.collision !== 1'b0 || bus0.dout_a !== 8'h00) begin
        failures++;
        $display("FAIL busy_ignore cyc=%0d vld=%b%b%b coll=%b dout=%h exp all 0", i,
                 bus0.vld_a, bus0.vld_b, bus1.vld_a, bus0.collision, bus0.dout_a);
      end
    end
    set_io(1'b1, 1'b0, 4'd2, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (bus0.dout_a !== 8'h00 || bus1.dout_a !== 8'h00 || bus0.vld_a !== 1'b1) begin
      failures++;
      $display("FAIL busy_addr2 got=%h,%h vld=%b exp=00,00 vld=1", bus0.dout_a, bus1.dout_a, bus0.vld_a);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus0.busy === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL mid_clear_busy_len got=%0d exp=16", cnt);
    end
    set_io(1'b1, 1'b1, 4'd9, 8'h3C, 1'b0, 1'b0, '0, '0);
    tick();
    set_io(1'b1, 1'b0, 4'd9, '0, 1'b1, 1'b0, 4'd9, '0);
    rst = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec[m] !== 20'h00001) begin
        failures++;
        $display("FAIL mid_ready_reset dut%0d got=%h exp=%h", m, obs_vec[m], 20'h00001);
      end
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (bus0.vld_a !== 1'b0 || bus0.vld_b !== 1'b0 || bus1.vld_a !== 1'b0 || bus1.vld_b !== 1'b0) begin
        failures++;
        $display("FAIL stray_vld cyc=%0d got=%b%b%b%b exp=0000", i, bus0.vld_a, bus0.vld_b, bus1.vld_a, bus1.vld_b);
      end
    end
    checks++;
    if (bus0.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_ready_busy_end got=%b exp=0", bus0.busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      set_io(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_vec[m] !== exp_vec(m)) begin
          failures++;
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", m, i, obs_vec[m], exp_vec(m));
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    idle();
    test_reset();
    test_fill();
    test_read_during_write();
    test_write_write();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/true_dual_port_ram.md
TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits per word, SHALL be 1..64.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en_a  input  1  port A access request.
REQ-007 we_a  input  1  port A write when en_a=1, read otherwise.
REQ-008 addr_a  input  ADDR_W  port A address.
REQ-009 din_a  input  DATA_W  port A write data.
REQ-010 dout_a  output  DATA_W  port A registered read data.
REQ-011 vld_a  output  1  one-cycle pulse marking dout_a updated.
REQ-012 en_b, we_b, addr_b, din_b, dout_b, vld_b SHALL mirror REQ-006..REQ-011 for port B.
REQ-013 busy  output  1  high while the memory clear sequence runs.
REQ-014 collision  output  1  one-cycle pulse flagging a same-address conflict.

Function
REQ-015 FSM states CLEAR and READY; rst forces CLEAR with clear counter = 0.
REQ-016 In CLEAR: write zero to address counter, counter+1 per cycle; leave to READY the cycle after writing address 2**ADDR_W-1 (exactly 2**ADDR_W cycles); busy=1 throughout.
REQ-017 In CLEAR all port requests SHALL be ignored: no write, vld_x=0, collision=0, dout_x hold.
REQ-018 In READY, en_x=1 & we_x=1 writes din_x to addr_x at the clock edge.
REQ-019 Every accepted access (read or write) SHALL update dout_x and pulse vld_x exactly 1 cycle later.
REQ-020 On a write, dout_x SHALL show old word if RD_MODE=0, din_x if RD_MODE=1.
REQ-021 Read on one port while the other writes the same address: returns old word if RD_MODE=0, written word if RD_MODE=1.
REQ-022 Both ports writing the same address in one cycle: port A data SHALL be stored; port B write discarded.
REQ-023 collision SHALL pulse 1 cycle after any cycle with en_a=en_b=1, addr_a=addr_b and (we_a|we_b)=1; read/read same address is not a collision.
REQ-024 With en_x=0, dout_x SHALL hold its last value (no high-impedance output).
REQ-025 Address wrap: addresses are exactly ADDR_W bits; no out-of-range accesses exist.

Reset
REQ-026 Synchronous rst SHALL set dout_a=dout_b=0, vld_a=vld_b=0, collision=0, busy=1 on the next edge.
REQ-027 rst asserted mid-CLEAR or mid-READY SHALL restart the clear from address 0; pending reads are dropped (no vld pulse).
REQ-028 Memory contents are defined only via the clear sequence; rst itself does not zero the array in one cycle.

Structure
REQ-029 Shared package tdp_ram_pkg SHALL hold RD_MODE constants (RD_FIRST=0, WR_FIRST=1) and the FSM state type.
REQ-030 Clear sequencer (FSM + counter + busy) SHALL be sub-module tdp_ram_clear_ctrl; array and port logic stay in the top.

Verification
REQ-031 Reset then idle: busy=1 for exactly 16 cycles (ADDR_W=4), then 0; reading all 16 addresses returns 0x00.
REQ-032 Port A writes 0x01..0x10 to addresses 0..15; port B reads 0..15 -> dout_b = 0x01..0x10, each 1 cycle after request with vld_b pulse.
REQ-033 RD_MODE=0: addr 3 holds 0x55; A writes 0xAA to 3 while B reads 3 -> dout_b=0x55, collision=1; next B read -> 0xAA; repeat with RD_MODE=1 -> dout_b=0xAA.
REQ-034 A writes 0x11, B writes 0x22, both to addr 7 same cycle -> collision=1; later read -> 0x11.
REQ-035 Write requests during busy (addr 2, 0x77) -> ignored, vld=0; after clear, addr 2 reads 0x00.
REQ-036 rst asserted at clear step 5 and again mid-READY -> busy restarts full 16-cycle count; outputs 0; no stray vld pulse.
